// File: rtl/tmds_channel_decoder.sv
// TMDS receive channel: symbol alignment via bit-slip search and 10b->8b/control decode.
// Optional TERC4 data-island decode is enabled by defining TMDS_TERC4_EN.
module tmds_channel_decoder #(
    parameter int CTRL_RUN_MIN   = 8,
    parameter int SEARCH_TIMEOUT = 2048,
    parameter int SLIP_SETTLE    = 3,
    parameter int LOSS_TIMEOUT   = 4096
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [9:0] symbol,
    output logic       bitslip,
    output logic       locked,
    output logic       de,
    output logic [1:0] ctrl,
    output logic [7:0] data
`ifdef TMDS_TERC4_EN
    ,
    input  logic       island,
    output logic [3:0] terc4,
    output logic       terc4_valid,
    output logic       sym_err
`endif
);

    localparam int RW = $clog2(CTRL_RUN_MIN + 1);
    localparam int TW = $clog2(SEARCH_TIMEOUT + 1);
    localparam int SW = $clog2(SLIP_SETTLE + 1);
    localparam int LW = $clog2(LOSS_TIMEOUT + 1);

    localparam logic [RW-1:0] RUN_LAST = RW'(CTRL_RUN_MIN - 1);
    localparam logic [RW-1:0] RUN_MAX  = RW'(CTRL_RUN_MIN);
    localparam logic [TW-1:0] TMR_LAST = TW'(SEARCH_TIMEOUT - 1);
    localparam logic [SW-1:0] STL_LAST = SW'(SLIP_SETTLE - 1);
    localparam logic [LW-1:0] LOS_LAST = LW'(LOSS_TIMEOUT - 1);

    typedef enum logic [1:0] {
        SEARCH,
        SETTLE,
        LOCK
    } state_t;

    state_t        state;
    logic [RW-1:0] run;
    logic [TW-1:0] timer;
    logic [SW-1:0] settle;
    logic [LW-1:0] loss;

    logic       is_tok;
    logic [1:0] code;
    logic [7:0] q;
    logic [7:0] d;
    logic [7:0] dx;
    logic       lock_next;

    always_comb begin
        is_tok = 1'b1;
        code   = 2'b00;
        unique case (symbol)
            10'b1101010100: code = 2'b00;
            10'b0010101011: code = 2'b01;
            10'b0101010100: code = 2'b10;
            10'b1010101011: code = 2'b11;
            default:        is_tok = 1'b0;
        endcase
    end

    // Undo the optional inversion, then the XOR/XNOR transition chain.
    assign q  = symbol[9] ? ~symbol[7:0] : symbol[7:0];
    assign dx = {q[7:1] ^ q[6:0], 1'b0};
    assign d  = {symbol[8] ? dx[7:1] : ~dx[7:1], q[0]};

`ifdef TMDS_TERC4_EN
    logic       hit;
    logic [3:0] nib;

    always_comb begin
        hit = 1'b1;
        nib = 4'h0;
        unique case (symbol)
            10'b1010011100: nib = 4'h0;
            10'b1001100011: nib = 4'h1;
            10'b1011100100: nib = 4'h2;
            10'b1011100010: nib = 4'h3;
            10'b0101110001: nib = 4'h4;
            10'b0100011110: nib = 4'h5;
            10'b0110001110: nib = 4'h6;
            10'b0100111100: nib = 4'h7;
            10'b1011001100: nib = 4'h8;
            10'b0100111001: nib = 4'h9;
            10'b0110011100: nib = 4'hA;
            10'b1011000110: nib = 4'hB;
            10'b1010001110: nib = 4'hC;
            10'b1001110001: nib = 4'hD;
            10'b0101100011: nib = 4'hE;
            10'b1011000011: nib = 4'hF;
            default:        hit = 1'b0;
        endcase
    end
`endif

    // Lock status after this edge; output gating follows it so a
    // dropped lock blanks the outputs on the same edge.
    always_comb begin
        lock_next = 1'b0;
        unique case (state)
            SEARCH:  lock_next = is_tok && (run >= RUN_LAST);
            LOCK:    lock_next = is_tok || (loss != LOS_LAST);
            default: lock_next = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= SEARCH;
            run     <= '0;
            timer   <= '0;
            settle  <= '0;
            loss    <= '0;
            bitslip <= 1'b0;
            locked  <= 1'b0;
            de      <= 1'b0;
            ctrl    <= 2'b00;
            data    <= 8'h00;
`ifdef TMDS_TERC4_EN
            terc4       <= 4'h0;
            terc4_valid <= 1'b0;
            sym_err     <= 1'b0;
`endif
        end else begin
            bitslip <= 1'b0;
            locked  <= lock_next;
            unique case (state)
                SEARCH: begin
                    if (!is_tok) begin
                        run <= '0;
                    end else if (run != RUN_MAX) begin
                        run <= run + 1'b1;
                    end
                    if (lock_next) begin
                        state <= LOCK;
                        loss  <= '0;
                    end else if (timer >= TMR_LAST) begin
                        state   <= SETTLE;
                        bitslip <= 1'b1;
                        settle  <= '0;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                SETTLE: begin
                    run   <= '0;
                    timer <= '0;
                    if (settle >= STL_LAST) begin
                        state <= SEARCH;
                    end else begin
                        settle <= settle + 1'b1;
                    end
                end
                LOCK: begin
                    if (is_tok) begin
                        loss <= '0;
                    end else if (!lock_next) begin
                        state <= SEARCH;
                        run   <= '0;
                        timer <= '0;
                    end else begin
                        loss <= loss + 1'b1;
                    end
                end
                default: state <= SEARCH;
            endcase

`ifdef TMDS_TERC4_EN
            terc4_valid <= 1'b0;
            sym_err     <= 1'b0;
`endif
            if (!lock_next) begin
                de   <= 1'b0;
                ctrl <= 2'b00;
                data <= 8'h00;
`ifdef TMDS_TERC4_EN
                terc4 <= 4'h0;
`endif
            end else if (is_tok) begin
                de   <= 1'b0;
                ctrl <= code;
`ifdef TMDS_TERC4_EN
            end else if (island) begin
                de          <= 1'b0;
                terc4_valid <= hit;
                sym_err     <= !hit;
                if (hit) begin
                    terc4 <= nib;
                end
`endif
            end else begin
                de   <= 1'b1;
                data <= d;
            end
        end
    end

endmodule

// File: tb/tb_tmds_channel_decoder.sv
// Bench for tmds_channel_decoder: reset, lock, decode table, loss of lock, slip search.
// Define TMDS_TERC4_EN to also exercise the data-island path.
module tb_tmds_channel_decoder;

    localparam logic [9:0] T0 = 10'b1101010100;
    localparam logic [9:0] T1 = 10'b0010101011;
    localparam logic [9:0] T2 = 10'b0101010100;
    localparam logic [9:0] T3 = 10'b1010101011;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [9:0] symbol = '0;
    logic       bitslip;
    logic       locked;
    logic       de;
    logic [1:0] ctrl;
    logic [7:0] data;
`ifdef TMDS_TERC4_EN
    logic       island = 1'b0;
    logic [3:0] terc4;
    logic       terc4_valid;
    logic       sym_err;
`endif

    tmds_channel_decoder #(
        .CTRL_RUN_MIN  (8),
        .SEARCH_TIMEOUT(32),
        .SLIP_SETTLE   (3),
        .LOSS_TIMEOUT  (64)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .symbol (symbol),
        .bitslip(bitslip),
        .locked (locked),
        .de     (de),
        .ctrl   (ctrl),
        .data   (data)
`ifdef TMDS_TERC4_EN
        ,
        .island     (island),
        .terc4      (terc4),
        .terc4_valid(terc4_valid),
        .sym_err    (sym_err)
`endif
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    typedef struct {
        logic [9:0] sym;
        logic       de;
        logic [1:0] ctrl;
        logic [7:0] data;
    } vec_t;

    vec_t tbl[12];
    vec_t sb[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    function automatic logic is_tok(input logic [9:0] w);
        return (w == T0) || (w == T1) || (w == T2) || (w == T3);
    endfunction

    // Transmit-side TMDS encoding with explicit mode and inversion choice.
    function automatic logic [9:0] enc(input logic [7:0] b, input logic x, input logic inv);
        logic [7:0] qm;
        logic [9:0] w;
        qm[0] = b[0];
        for (int i = 1; i < 8; i++) begin
            qm[i] = x ? (qm[i-1] ^ b[i]) : ~(qm[i-1] ^ b[i]);
        end
        w = {inv, x, inv ? ~qm : qm};
        if (is_tok(w)) begin
            w = {~inv, x, inv ? qm : ~qm};
        end
        return w;
    endfunction

    function automatic logic [9:0] rot(input logic [9:0] w, input int r);
        logic [19:0] t;
        t = {w, w} >> r;
        return t[9:0];
    endfunction

    task automatic cyc(input logic [9:0] s);
        @(negedge clk);
        symbol = s;
        @(posedge clk);
        #1;
    endtask

    task automatic apply(input vec_t v, input int n);
        vec_t e;
        sb.push_back(v);
        cyc(v.sym);
        e = sb.pop_front();
        check($sformatf("de[%0d]", n), de, e.de);
        check($sformatf("ctrl[%0d]", n), ctrl, e.ctrl);
        check($sformatf("data[%0d]", n), data, e.data);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int r;
        int n;
        int nslip;
        int last;
        int lockn;
        vec_t v;

        tbl[0]  = '{T0, 1'b0, 2'b00, 8'hA5};
        tbl[1]  = '{T1, 1'b0, 2'b01, 8'hA5};
        tbl[2]  = '{T2, 1'b0, 2'b10, 8'hA5};
        tbl[3]  = '{T3, 1'b0, 2'b11, 8'hA5};
        tbl[4]  = '{enc(8'h3C, 1'b1, 1'b0), 1'b1, 2'b11, 8'h3C};
        tbl[5]  = '{enc(8'h00, 1'b0, 1'b1), 1'b1, 2'b11, 8'h00};
        tbl[6]  = '{enc(8'hFF, 1'b1, 1'b1), 1'b1, 2'b11, 8'hFF};
        tbl[7]  = '{enc(8'h5A, 1'b0, 1'b0), 1'b1, 2'b11, 8'h5A};
        tbl[8]  = '{T1, 1'b0, 2'b01, 8'h5A};
        tbl[9]  = '{enc(8'h81, 1'b1, 1'b0), 1'b1, 2'b01, 8'h81};
        tbl[10] = '{T2, 1'b0, 2'b10, 8'h81};
        tbl[11] = '{enc(8'h7E, 1'b0, 1'b1), 1'b1, 2'b10, 8'h7E};

        rst = 1'b0;
        for (int i = 0; i < 2; i++) cyc(10'($urandom));
        check("rst_bitslip", bitslip, 0);
        check("rst_locked", locked, 0);
        check("rst_de", de, 0);
        check("rst_ctrl", ctrl, 0);
        check("rst_data", data, 0);
        rst = 1'b1;

        for (int i = 0; i < 7; i++) cyc(T0);
        cyc(enc(8'h12, 1'b1, 1'b0));
        check("no_lock_7", locked, 0);
        for (int i = 0; i < 8; i++) begin
            cyc(T0);
            if (i == 6) check("lock_after_7", locked, 0);
        end
        check("lock_after_8", locked, 1);
        v = '{enc(8'hA5, 1'b1, 1'b0), 1'b1, 2'b00, 8'hA5};
        apply(v, 99);

        for (int i = 0; i < 12; i++) apply(tbl[i], i);

        cyc(T0);
        for (int i = 1; i <= 62; i++) cyc(enc(8'h11, 1'b0, 1'b0));
        cyc(T0);
        check("hold_tok63", locked, 1);
        for (int i = 1; i <= 64; i++) begin
            cyc(enc(8'h6D, 1'b1, 1'b0));
            if (i == 10) check("loss_de", de, 1);
            if (i == 10) check("loss_data", data, 8'h6D);
            if (i == 63) check("loss_63", locked, 1);
        end
        check("loss_64", locked, 0);
        check("loss_de0", de, 0);
        check("loss_ctrl0", ctrl, 0);
        check("loss_data0", data, 0);

        rst = 1'b0;
        for (int i = 0; i < 2; i++) cyc(T2);
        rst = 1'b1;
        n = 0;
        for (int i = 0; i < 100; i++) begin
            cyc(rot(T0, 3));
            n++;
            if (bitslip) break;
        end
        check("first_slip", n, 32);
        rst = 1'b0;
        cyc(rot(T0, 3));
        check("rst_settle_slip", bitslip, 0);
        check("rst_settle_lock", locked, 0);
        cyc(rot(T0, 3));
        rst = 1'b1;

        r = 3;
        n = 0;
        nslip = 0;
        last = 0;
        lockn = 0;
        for (int i = 0; i < 400; i++) begin
            cyc(rot(T0, r));
            n++;
            if (bitslip) begin
                if (nslip > 0) check($sformatf("slip_gap%0d", nslip), n - last, 35);
                nslip++;
                last = n;
                r = (r + 9) % 10;
            end
            if (locked) begin
                lockn = n;
                break;
            end
        end
        check("slip_count", nslip, 3);
        check("rot_locked", locked, 1);
        check("rot_lock_delay", lockn - last, 11);
        cyc(T0);
        check("no_slip_locked", bitslip, 0);

`ifdef TMDS_TERC4_EN
        island = 1'b1;
        cyc(10'b1010011100);
        check("terc4_0", terc4, 4'h0);
        check("terc4_v0", terc4_valid, 1);
        check("terc4_de0", de, 0);
        check("terc4_err0", sym_err, 0);
        cyc(10'b1111111111);
        check("terc4_err", sym_err, 1);
        check("terc4_verr", terc4_valid, 0);
        check("terc4_deerr", de, 0);
        cyc(10'b1011000011);
        check("terc4_f", terc4, 4'hF);
        check("terc4_vf", terc4_valid, 1);
        cyc(T3);
        check("terc4_tok", ctrl, 2'b11);
        island = 1'b0;
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
